// File: rtl/alu_result_serializer.sv
// Captures one ALU result plus flags and streams it out as a byte frame on an
// 8-bit valid/ready port; results arriving while a frame is in flight are counted as drops.
module alu_result_serializer #(
    parameter bit          LSB_FIRST  = 1'b1,
    parameter bit          SEND_FLAGS = 1'b1,
    parameter int unsigned DROP_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              res_valid,
    input  logic [31:0]       res_data,
    input  logic [3:0]        res_flags,
    output logic              res_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int unsigned N = SEND_FLAGS ? 5 : 4;
    localparam logic [2:0] LAST_IDX = 3'(N - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t            state_q, state_d;
    logic [35:0]       frame_q, frame_d;
    logic [2:0]        idx_q, idx_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic       acc;
    logic       hs;
    logic       drop;
    logic       at_last;
    logic [2:0] data_idx;
    logic [1:0] pos;
    logic [7:0] cur_byte;

    assign tx_valid  = (state_q == SEND);
    assign busy      = tx_valid;
    assign at_last   = (idx_q == LAST_IDX);
    assign tx_last   = tx_valid & at_last;
    assign hs        = ena & tx_valid & tx_ready;
    assign res_ready = (state_q == IDLE) | (hs & at_last);
    assign acc       = ena & res_valid & res_ready;
    assign drop      = ena & res_valid & ~res_ready;
    assign drop_cnt  = drop_q;

    // Data byte position within the result word, after skipping the header slot.
    always_comb begin
        data_idx = SEND_FLAGS ? (idx_q - 3'd1) : idx_q;
        pos      = LSB_FIRST ? data_idx[1:0] : (2'd3 - data_idx[1:0]);
        case (pos)
            2'd0:    cur_byte = frame_q[7:0];
            2'd1:    cur_byte = frame_q[15:8];
            2'd2:    cur_byte = frame_q[23:16];
            default: cur_byte = frame_q[31:24];
        endcase
        if (SEND_FLAGS && (idx_q == 3'd0)) begin
            cur_byte = {4'hA, frame_q[35:32]};
        end
    end

    assign tx_data = tx_valid ? cur_byte : 8'h00;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        drop_d  = drop_q;

        if (acc) begin
            frame_d = {res_flags, res_data};
            idx_d   = '0;
            state_d = SEND;
        end else if (hs) begin
            if (at_last) begin
                idx_d   = '0;
                state_d = IDLE;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end

        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            frame_q <= '0;
            idx_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Checks two serializer variants against a byte-queue frame model under directed and random stimulus.
module tb_alu_result_serializer;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        res_valid;
    logic [31:0] res_data;
    logic [3:0]  res_flags;
    logic        tx_ready;

    logic        res_ready_a, tx_valid_a, tx_last_a, busy_a;
    logic [7:0]  tx_data_a, drop_cnt_a;
    logic        res_ready_b, tx_valid_b, tx_last_b, busy_b;
    logic [7:0]  tx_data_b, drop_cnt_b;

    int checks   = 0;
    int failures = 0;

    byte_q_t qa, qb;
    int      da, db;

    always #5 clk = ~clk;

    alu_result_serializer #(
        .LSB_FIRST (1'b1),
        .SEND_FLAGS(1'b1),
        .DROP_W    (8)
    ) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_flags(res_flags),
        .res_ready(res_ready_a),
        .tx_data  (tx_data_a),
        .tx_valid (tx_valid_a),
        .tx_ready (tx_ready),
        .tx_last  (tx_last_a),
        .busy     (busy_a),
        .drop_cnt (drop_cnt_a)
    );

    alu_result_serializer #(
        .LSB_FIRST (1'b0),
        .SEND_FLAGS(1'b0),
        .DROP_W    (8)
    ) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_flags(res_flags),
        .res_ready(res_ready_b),
        .tx_data  (tx_data_b),
        .tx_valid (tx_valid_b),
        .tx_ready (tx_ready),
        .tx_last  (tx_last_b),
        .busy     (busy_b),
        .drop_cnt (drop_cnt_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic byte_q_t build_frame(input bit lsb, input bit sf,
                                            input logic [31:0] d, input logic [3:0] f);
        byte_q_t q;
        if (sf) q.push_back({4'hA, f});
        for (int i = 0; i < 4; i++) begin
            q.push_back(d[8*(lsb ? i : 3 - i) +: 8]);
        end
        return q;
    endfunction

    // Compare one variant against the model, then advance the model across the coming edge.
    task automatic step_model(input bit lsb, input bit sf, input string nm,
                              input byte_q_t qin, input int din,
                              input logic rdy_g, input logic vld_g, input logic [7:0] dat_g,
                              input logic last_g, input logic busy_g, input logic [7:0] drop_g,
                              output byte_q_t qout, output int dout);
        int   sz;
        logic exp_rdy;
        sz      = qin.size();
        exp_rdy = (sz == 0) || (ena && tx_ready && sz == 1);
        check_eq({nm, "_res_ready"}, 32'(rdy_g),  32'(exp_rdy));
        check_eq({nm, "_tx_valid"},  32'(vld_g),  32'(sz > 0));
        check_eq({nm, "_busy"},      32'(busy_g), 32'(sz > 0));
        check_eq({nm, "_tx_data"},   32'(dat_g),  (sz > 0) ? 32'(qin[0]) : 32'h0);
        check_eq({nm, "_tx_last"},   32'(last_g), 32'(sz == 1));
        check_eq({nm, "_drop_cnt"},  32'(drop_g), 32'(din));
        qout = qin;
        dout = din;
        if (ena && sz > 0 && tx_ready) qout.delete(0);
        if (ena && res_valid && exp_rdy) qout = build_frame(lsb, sf, res_data, res_flags);
        else if (ena && res_valid && !exp_rdy && din < 255) dout = din + 1;
    endtask

    task automatic cyc(input logic e, input logic rv, input logic [31:0] d,
                       input logic [3:0] f, input logic tr);
        @(negedge clk);
        ena       = e;
        res_valid = rv;
        res_data  = d;
        res_flags = f;
        tx_ready  = tr;
        #1;
        step_model(1'b1, 1'b1, "A", qa, da, res_ready_a, tx_valid_a, tx_data_a,
                   tx_last_a, busy_a, drop_cnt_a, qa, da);
        step_model(1'b0, 1'b0, "B", qb, db, res_ready_b, tx_valid_b, tx_data_b,
                   tx_last_b, busy_b, drop_cnt_b, qb, db);
    endtask

    task automatic idle_cycles(input int n, input logic tr);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0, 4'h0, tr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        res_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        qa = {};
        qb = {};
        da = 0;
        db = 0;
        check_eq("rst_A_tx_valid",  32'(tx_valid_a),  32'h0);
        check_eq("rst_A_tx_data",   32'(tx_data_a),   32'h0);
        check_eq("rst_A_tx_last",   32'(tx_last_a),   32'h0);
        check_eq("rst_A_busy",      32'(busy_a),      32'h0);
        check_eq("rst_A_drop_cnt",  32'(drop_cnt_a),  32'h0);
        check_eq("rst_A_res_ready", 32'(res_ready_a), 32'h1);
        check_eq("rst_B_tx_valid",  32'(tx_valid_b),  32'h0);
        check_eq("rst_B_res_ready", 32'(res_ready_b), 32'h1);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        res_flags = '0;
        tx_ready  = 1'b0;
        qa = {};
        qb = {};
        da = 0;
        db = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_reset();

        // Single frame, then a second result landing on A's last-byte handshake.
        cyc(1'b1, 1'b1, 32'h12345678, 4'b0010, 1'b1);
        idle_cycles(4, 1'b1);
        cyc(1'b1, 1'b1, 32'hCAFEF00D, 4'b1000, 1'b1);
        idle_cycles(2, 1'b1);
        cyc(1'b1, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1);
        idle_cycles(4, 1'b1);

        // Backpressure on the same frame.
        cyc(1'b1, 1'b1, 32'h12345678, 4'b0010, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 32'h0, 4'h0, ($urandom_range(0, 99) < 40));
        idle_cycles(6, 1'b1);

        // Enable gating during byte 1 with result strobes present.
        cyc(1'b1, 1'b1, 32'h0BADF00D, 4'b0101, 1'b1);
        idle_cycles(1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, $urandom, 4'h3, 1'b1);
        idle_cycles(8, 1'b1);

        // Saturating drop counter.
        cyc(1'b1, 1'b1, 32'h55AA55AA, 4'h1, 1'b0);
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, $urandom, 4'h2, 1'b0);
        idle_cycles(8, 1'b1);

        // Reset mid-frame, then a fresh frame starts from byte 0.
        cyc(1'b1, 1'b1, 32'h12345678, 4'b0010, 1'b1);
        idle_cycles(3, 1'b1);
        do_reset();
        cyc(1'b1, 1'b1, 32'h87654321, 4'b1001, 1'b1);
        idle_cycles(6, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 3), $urandom,
                4'($urandom), ($urandom_range(0, 9) < 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
